ram_arbiter: RTL and testbench
==============================

# ram_arbiter

Two-port arbiter that shares the single-port, synchronous data RAM (2^RAM_AW words of DW bits) between the processor core (port 0) and a debug/loader master (port 1). Sits between the requesters and the RAM macro inside SoC. It grants one access per cycle using round-robin, returns read data one cycle later tagged to the owning port, and can hold the grant for locked multi-word sequences.

## Interface
- DW, 16, data width
- RAM_AW, 7, RAM word address width
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  asynchronous, active-low reset
- req0 / req1  in  1  access request, port 0 / port 1
- we0 / we1  in  1  1 = write, 0 = read
- addr0 / addr1  in  RAM_AW  word address
- wdata0 / wdata1  in  DW  write data
- lock0 / lock1  in  1  keep the grant after this access (active only with RAM_ARB_LOCK_EN)
- gnt0 / gnt1  out  1  combinational; the access is accepted this cycle
- rvalid0 / rvalid1  out  1  read data valid, one cycle after a granted read
- rdata  out  DW  read data, shared by both ports and qualified by rvalidN
- ram_en, ram_we  out  1  RAM enable and write strobe
- ram_addr  out  RAM_AW  RAM address
- ram_wdata  out  DW  RAM write data
- ram_rdata  in  DW  RAM read data, valid the cycle after ram_en with ram_we=0

## Operation
- State register `last` (1 bit): the port granted most recently. Reset value 1, so port 0 wins the first contention.
- Arbitration is combinational:
  - Only one port requesting: that port is granted.
  - Both ports requesting: the port that is not `last` is granted.
  - At most one gnt is high in any cycle.
- Mux: ram_en = gnt0|gnt1. ram_we, ram_addr and ram_wdata come from the granted port. When no port is granted, all four are driven to 0.
- A port holds req, we, addr and wdata stable until it sees gnt. A request can be withdrawn while ungranted, with no side effect.
- Read return: on a granted read, register `rd_own` = port index and `rd_pend` = 1. In the next cycle, rvalid[rd_own] = rd_pend, and rdata passes ram_rdata straight through.
- Writes produce no rvalid.
- `last` updates on every grant.
- Reset asserted mid-operation: gnt, ram_en and rvalid drop to 0 immediately (asynchronous reset). Pending reads are lost. `last` returns to 1.
- Back-to-back accesses are allowed. The same port may be granted on consecutive cycles if the other port is idle.

## Timing
- Reset value of all outputs is 0, and rst forces every output low regardless of input state.
- Grant latency is 0 cycles: gnt is high in the same cycle as req when that port wins.
- Read latency is exactly 1 cycle from the gnt edge to rvalid.
- Throughput is one access per cycle.
- Worst-case wait under contention without lock is 1 cycle.
- Read-after-write to the same address from either port: the value returned is the value written, because the RAM write completes before the next cycle's read.

## Configuration
- RAM_ARB_LOCK_EN defined:
  - Adds a lock state machine with states IDLE, OWN0 and OWN1.
  - A grant to port N with lockN=1 moves the FSM to OWNN.
  - While in OWNN, only port N can be granted and the other port waits.
  - A grant to port N with lockN=0, or a cycle in which reqN=0, returns the FSM to IDLE.
  - Reset state is IDLE.
- RAM_ARB_LOCK_EN undefined: lock0 and lock1 are ignored, no FSM is instantiated, and arbitration is pure round-robin.

## Structure
- Shared package yd_pkg holds DW and RAM_AW defaults and the `arb_state_t` enum (IDLE, OWN0, OWN1).
- One sub-module, `rr_pick2`: combinational two-way round-robin selector with inputs req[1:0], last and force[1:0] (driven by the lock FSM), and output gnt[1:0].

## Test plan
- Reset, then req0=1, we0=1, addr0=7'h05, wdata0=16'hFA1C. Expected: gnt0=1 in the same cycle; a following port-1 read of 7'h05 returns 16'hFA1C with rvalid1=1 one cycle after gnt1.
- req0 and req1 both held high as reads for 4 cycles. Expected: grants alternate 0,1,0,1, and each rvalid follows its own grant by one cycle.
- req1 alone for 3 cycles. Expected: gnt1 on 3 consecutive cycles and ram_en=1 throughout.
- rst driven low while a read is pending. Expected: rvalid0, rvalid1 and ram_en=0 immediately. After release, a contended request is granted to port 0.
- With RAM_ARB_LOCK_EN: port 1 does 3 writes with lock1=1,1,0 while req0 is held high. Expected: gnt1,gnt1,gnt1 then gnt0; no gnt0 before the unlocked access.
- Without RAM_ARB_LOCK_EN: repeat the previous stimulus. Expected: strict alternation.

Source files
------------

// File: rtl/yd_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package     : yd_pkg                                                       |
// | Description : Shared defaults and lock-FSM state type for ram_arbiter.     |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
package yd_pkg;

    localparam int DEF_DW     = 16;
    localparam int DEF_RAM_AW = 7;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } arb_state_t;

endpackage : yd_pkg
`default_nettype wire

// File: rtl/ram_arbiter_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Interface   : ram_arbiter_if                                               |
// | Description : Requester ports and RAM macro port of the two-way arbiter.   |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
interface ram_arbiter_if #(
    parameter int DW     = yd_pkg::DEF_DW,
    parameter int RAM_AW = yd_pkg::DEF_RAM_AW
);
    logic              req0;
    logic              we0;
    logic [RAM_AW-1:0] addr0;
    logic [DW-1:0]     wdata0;
    logic              lock0;
    logic              req1;
    logic              we1;
    logic [RAM_AW-1:0] addr1;
    logic [DW-1:0]     wdata1;
    logic              lock1;
    logic              gnt0;
    logic              gnt1;
    logic              rvalid0;
    logic              rvalid1;
    logic [DW-1:0]     rdata;
    logic              ram_en;
    logic              ram_we;
    logic [RAM_AW-1:0] ram_addr;
    logic [DW-1:0]     ram_wdata;
    logic [DW-1:0]     ram_rdata;

    // Arbiter side
    modport slave (
        input  req0, we0, addr0, wdata0, lock0,
        input  req1, we1, addr1, wdata1, lock1,
        input  ram_rdata,
        output gnt0, gnt1, rvalid0, rvalid1, rdata,
        output ram_en, ram_we, ram_addr, ram_wdata
    );

    // Requesters plus RAM macro side
    modport master (
        output req0, we0, addr0, wdata0, lock0,
        output req1, we1, addr1, wdata1, lock1,
        output ram_rdata,
        input  gnt0, gnt1, rvalid0, rvalid1, rdata,
        input  ram_en, ram_we, ram_addr, ram_wdata
    );

endinterface : ram_arbiter_if
`default_nettype wire

// File: rtl/ram_arbiter_rr_pick2.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : rr_pick2                                                     |
// | Description : Combinational two-way round-robin selector with force mask.  |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
module rr_pick2 (
    input  wire logic [1:0] req,
    input  wire logic       last,
    input  wire logic [1:0] force_sel,
    output logic      [1:0] gnt
);

    always_comb begin
        gnt = 2'b00;
        // A non-zero force mask restricts eligibility to the owning port
        if (force_sel != 2'b00) begin
            gnt = req & force_sel;
        end else if (req == 2'b11) begin
            gnt = last ? 2'b01 : 2'b10;
        end else begin
            gnt = req;
        end
    end

endmodule : rr_pick2
`default_nettype wire

// File: rtl/ram_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : ram_arbiter                                                  |
// | Description : Round-robin arbiter sharing a single-port sync RAM between   |
// |               two masters. Define RAM_ARB_LOCK_EN for locked sequences.    |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
module ram_arbiter
    import yd_pkg::*;
#(
    parameter int DW     = DEF_DW,
    parameter int RAM_AW = DEF_RAM_AW
) (
    input  wire logic    clk,
    input  wire logic    rst,
    ram_arbiter_if.slave bus
);

    logic              r_last;
    logic              r_rd_pend;
    logic              r_rd_own;
    logic [1:0]        w_req;
    logic [1:0]        w_force;
    logic [1:0]        w_pick;
    logic [1:0]        w_gnt;
    logic              w_en;
    logic              w_we;
    logic [RAM_AW-1:0] w_addr;
    logic [DW-1:0]     w_wdata;

    assign w_req = {bus.req1, bus.req0};

`ifdef RAM_ARB_LOCK_EN
    arb_state_t r_state;
    arb_state_t w_state_nxt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_force     = 2'b00;
        case (r_state)
            IDLE: begin
                if (w_gnt[0] && bus.lock0) begin
                    w_state_nxt = OWN0;
                end else if (w_gnt[1] && bus.lock1) begin
                    w_state_nxt = OWN1;
                end
            end
            OWN0: begin
                w_force = 2'b01;
                if (!bus.req0 || (w_gnt[0] && !bus.lock0)) begin
                    w_state_nxt = IDLE;
                end
            end
            OWN1: begin
                w_force = 2'b10;
                if (!bus.req1 || (w_gnt[1] && !bus.lock1)) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end
`else
    logic w_unused_lock;
    assign w_unused_lock = bus.lock0 | bus.lock1;
    assign w_force       = 2'b00;
`endif

    rr_pick2 u_pick (
        .req       (w_req),
        .last      (r_last),
        .force_sel (w_force),
        .gnt       (w_pick)
    );

    // Reset must silence the combinational grant path as well as the registers
    assign w_gnt = rst ? w_pick : 2'b00;

    always_comb begin
        w_en    = 1'b0;
        w_we    = 1'b0;
        w_addr  = '0;
        w_wdata = '0;
        if (w_gnt[0]) begin
            w_en    = 1'b1;
            w_we    = bus.we0;
            w_addr  = bus.addr0;
            w_wdata = bus.wdata0;
        end else if (w_gnt[1]) begin
            w_en    = 1'b1;
            w_we    = bus.we1;
            w_addr  = bus.addr1;
            w_wdata = bus.wdata1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_last    <= 1'b1;
            r_rd_pend <= 1'b0;
            r_rd_own  <= 1'b0;
        end else begin
            if (w_en) begin
                r_last <= w_gnt[1];
            end
            r_rd_pend <= w_en & ~w_we;
            r_rd_own  <= w_gnt[1];
        end
    end

    assign bus.gnt0      = w_gnt[0];
    assign bus.gnt1      = w_gnt[1];
    assign bus.ram_en    = w_en;
    assign bus.ram_we    = w_we;
    assign bus.ram_addr  = w_addr;
    assign bus.ram_wdata = w_wdata;
    assign bus.rvalid0   = r_rd_pend & ~r_rd_own;
    assign bus.rvalid1   = r_rd_pend &  r_rd_own;
    assign bus.rdata     = rst ? bus.ram_rdata : '0;

endmodule : ram_arbiter
`default_nettype wire

// File: tb/tb_ram_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_ram_arbiter                                               |
// | Description : Vector-table bench for ram_arbiter with a behavioural RAM.   |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
module tb_ram_arbiter;

    logic clk;
    logic rst;

    ram_arbiter_if #(.DW(16), .RAM_AW(7)) bus ();

    ram_arbiter #(.DW(16), .RAM_AW(7)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [15:0] mem [0:127];
    always @(posedge clk) begin
        if (bus.ram_en) begin
            if (bus.ram_we) mem[bus.ram_addr] <= bus.ram_wdata;
            else            bus.ram_rdata     <= mem[bus.ram_addr];
        end
    end

    typedef struct {
        logic        rst;
        logic        r0, w0, l0;
        logic [6:0]  a0;
        logic [15:0] d0;
        logic        r1, w1, l1;
        logic [6:0]  a1;
        logic [15:0] d1;
        logic [5:0]  ex;    // {gnt0, gnt1, rvalid0, rvalid1, ram_en, ram_we}
        logic [6:0]  ea;
        logic [15:0] ed;
        logic        chk;
        logic [15:0] rd;
    } vec_t;

    vec_t vq[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic add(input logic rs,
                       input logic r0, input logic w0, input logic [6:0] a0, input logic [15:0] d0, input logic l0,
                       input logic r1, input logic w1, input logic [6:0] a1, input logic [15:0] d1, input logic l1,
                       input logic [5:0] ex, input logic [6:0] ea, input logic [15:0] ed,
                       input logic chk, input logic [15:0] rd);
        vec_t v;
        v.rst = rs;
        v.r0 = r0; v.w0 = w0; v.a0 = a0; v.d0 = d0; v.l0 = l0;
        v.r1 = r1; v.w1 = w1; v.a1 = a1; v.d1 = d1; v.l1 = l1;
        v.ex = ex; v.ea = ea; v.ed = ed; v.chk = chk; v.rd = rd;
        vq.push_back(v);
    endtask

    task automatic drive(input vec_t v);
        rst        = v.rst;
        bus.req0   = v.r0; bus.we0 = v.w0; bus.addr0 = v.a0; bus.wdata0 = v.d0; bus.lock0 = v.l0;
        bus.req1   = v.r1; bus.we1 = v.w1; bus.addr1 = v.a1; bus.wdata1 = v.d1; bus.lock1 = v.l1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [28:0] outs();
        return {bus.gnt0, bus.gnt1, bus.rvalid0, bus.rvalid1, bus.ram_en, bus.ram_we,
                bus.ram_addr, bus.ram_wdata};
    endfunction

    initial begin
        vec_t idle;
        idle = '{rst:1'b0, r0:1'b0, w0:1'b0, l0:1'b0, a0:7'h0, d0:16'h0,
                 r1:1'b0, w1:1'b0, l1:1'b0, a1:7'h0, d1:16'h0,
                 ex:6'h0, ea:7'h0, ed:16'h0, chk:1'b0, rd:16'h0};
        drive(idle);

        //   rst r0 w0 a0     d0        l0  r1 w1 a1     d1        l1  ex         ea     ed        chk rd
        add(0,  1, 0, 7'h05, 16'h0000, 0,  1, 0, 7'h10, 16'h0000, 0,  6'b000000, 7'h00, 16'h0000, 0, 16'h0000);
        add(1,  1, 1, 7'h05, 16'hFA1C, 0,  0, 0, 7'h00, 16'h0000, 0,  6'b100011, 7'h05, 16'hFA1C, 0, 16'h0000);
        add(1,  0, 0, 7'h00, 16'h0000, 0,  1, 0, 7'h05, 16'h0000, 0,  6'b010010, 7'h05, 16'h0000, 0, 16'h0000);
        add(1,  0, 0, 7'h00, 16'h0000, 0,  0, 0, 7'h00, 16'h0000, 0,  6'b000100, 7'h00, 16'h0000, 1, 16'hFA1C);
        add(1,  1, 1, 7'h11, 16'hABCD, 0,  0, 0, 7'h00, 16'h0000, 0,  6'b100011, 7'h11, 16'hABCD, 0, 16'h0000);
        add(1,  0, 0, 7'h00, 16'h0000, 0,  1, 1, 7'h10, 16'h1234, 0,  6'b010011, 7'h10, 16'h1234, 0, 16'h0000);
        add(1,  1, 0, 7'h10, 16'h0000, 0,  1, 0, 7'h11, 16'h0000, 0,  6'b100010, 7'h10, 16'h0000, 0, 16'h0000);
        add(1,  1, 0, 7'h10, 16'h0000, 0,  1, 0, 7'h11, 16'h0000, 0,  6'b011010, 7'h11, 16'h0000, 1, 16'h1234);
        add(1,  1, 0, 7'h10, 16'h0000, 0,  1, 0, 7'h11, 16'h0000, 0,  6'b100110, 7'h10, 16'h0000, 1, 16'hABCD);
        add(1,  1, 0, 7'h10, 16'h0000, 0,  1, 0, 7'h11, 16'h0000, 0,  6'b011010, 7'h11, 16'h0000, 1, 16'h1234);
        add(1,  0, 0, 7'h00, 16'h0000, 0,  1, 0, 7'h05, 16'h0000, 0,  6'b010110, 7'h05, 16'h0000, 1, 16'hABCD);
        add(1,  0, 0, 7'h00, 16'h0000, 0,  1, 0, 7'h10, 16'h0000, 0,  6'b010110, 7'h10, 16'h0000, 1, 16'hFA1C);
        add(1,  0, 0, 7'h00, 16'h0000, 0,  1, 0, 7'h11, 16'h0000, 0,  6'b010110, 7'h11, 16'h0000, 1, 16'h1234);
        add(0,  1, 0, 7'h05, 16'h0000, 0,  1, 0, 7'h10, 16'h0000, 0,  6'b000000, 7'h00, 16'h0000, 0, 16'h0000);
        add(1,  1, 0, 7'h05, 16'h0000, 0,  1, 0, 7'h10, 16'h0000, 0,  6'b100010, 7'h05, 16'h0000, 0, 16'h0000);
        add(1,  0, 0, 7'h00, 16'h0000, 0,  0, 0, 7'h00, 16'h0000, 0,  6'b001000, 7'h00, 16'h0000, 1, 16'hFA1C);
        add(1,  1, 0, 7'h05, 16'h0000, 0,  1, 1, 7'h20, 16'h0001, 1,  6'b010011, 7'h20, 16'h0001, 0, 16'h0000);
`ifdef RAM_ARB_LOCK_EN
        add(1,  1, 0, 7'h05, 16'h0000, 0,  1, 1, 7'h21, 16'h0002, 1,  6'b010011, 7'h21, 16'h0002, 0, 16'h0000);
        add(1,  1, 0, 7'h05, 16'h0000, 0,  1, 1, 7'h22, 16'h0003, 0,  6'b010011, 7'h22, 16'h0003, 0, 16'h0000);
        add(1,  1, 0, 7'h05, 16'h0000, 0,  0, 0, 7'h00, 16'h0000, 0,  6'b100010, 7'h05, 16'h0000, 0, 16'h0000);
        add(1,  0, 0, 7'h00, 16'h0000, 0,  0, 0, 7'h00, 16'h0000, 0,  6'b001000, 7'h00, 16'h0000, 1, 16'hFA1C);
`else
        add(1,  1, 0, 7'h05, 16'h0000, 0,  1, 1, 7'h21, 16'h0002, 1,  6'b100010, 7'h05, 16'h0000, 0, 16'h0000);
        add(1,  1, 0, 7'h05, 16'h0000, 0,  1, 1, 7'h21, 16'h0002, 1,  6'b011011, 7'h21, 16'h0002, 1, 16'hFA1C);
        add(1,  1, 0, 7'h05, 16'h0000, 0,  1, 1, 7'h22, 16'h0003, 0,  6'b100010, 7'h05, 16'h0000, 0, 16'h0000);
        add(1,  0, 0, 7'h00, 16'h0000, 0,  1, 1, 7'h22, 16'h0003, 0,  6'b011011, 7'h22, 16'h0003, 1, 16'hFA1C);
`endif
        add(1,  1, 0, 7'h22, 16'h0000, 0,  0, 0, 7'h00, 16'h0000, 0,  6'b100010, 7'h22, 16'h0000, 0, 16'h0000);
        add(1,  0, 0, 7'h00, 16'h0000, 0,  0, 0, 7'h00, 16'h0000, 0,  6'b001000, 7'h00, 16'h0000, 1, 16'h0003);

        foreach (vq[i]) begin
            @(negedge clk);
            drive(vq[i]);
            #1;
            check($sformatf("row%0d_outs", i), {3'b0, outs()}, {3'b0, vq[i].ex, vq[i].ea, vq[i].ed});
            if (vq[i].chk) check($sformatf("row%0d_rdata", i), {16'h0, bus.rdata}, {16'h0, vq[i].rd});
        end

        // Asynchronous reset landing mid-cycle while a read is outstanding
        @(negedge clk);
        idle.rst = 1'b1;
        drive(idle);
        bus.req0  = 1'b1;
        bus.addr0 = 7'h20;
        #1;
        check("async_pre_gnt0", {31'h0, bus.gnt0}, 32'h1);
        @(posedge clk);
        #1;
        check("async_pend_rvalid0", {31'h0, bus.rvalid0}, 32'h1);
        #1;
        rst = 1'b0;
        #1;
        check("async_drop", {29'h0, bus.rvalid0, bus.ram_en, bus.gnt0}, 32'h0);
        @(negedge clk);
        rst       = 1'b1;
        bus.req1  = 1'b1;
        bus.addr1 = 7'h21;
        #1;
        check("post_reset_contend", {30'h0, bus.gnt0, bus.gnt1}, 32'h2);
        @(negedge clk);
        bus.req0 = 1'b0;
        bus.req1 = 1'b0;
        #1;
        check("post_reset_read", {15'h0, bus.rvalid0, bus.rdata}, {15'h0, 1'b1, 16'h0001});

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_ram_arbiter
`default_nettype wire
